axil_stream_bridge_mc: RTL
==========================

// Module: axil_stream_bridge_mc
// PURPOSE
//  Multi-channel AXI-Lite slave <-> AXI-Stream bridge. Replaces the single-word
//  converter by giving the CPU NUM_CH independent stream channels.
//  Each channel has a TX FIFO (AXI-Lite write -> m_axis), an RX pop register
//  (s_axis -> AXI-Lite read) and a STATUS register.
//  Full or empty conditions are non-blocking: they return SLVERR and never stall the bus.
// PARAMETERS
//  DATA_W    32        AXI-Lite data and AXI-Stream tdata width (32 or 64)
//  ADDR_W    32        AXI-Lite address width
//  BASE_ADDR 32'h0     byte base address of channel 0
//  NUM_CH    2         number of stream channels (1..16)
//  TX_DEPTH  4         TX FIFO depth per channel, power of 2, >=2
// PORTS
//  aclk            in   1               clock; all logic on posedge
//  aresetn         in   1               synchronous, active-low reset
//  s_axil_aw*      -    awaddr[ADDR_W], awvalid in; awready out
//  s_axil_w*       -    wdata[DATA_W], wvalid in; wready out
//  s_axil_b*       -    bresp[2], bvalid out; bready in
//  s_axil_ar*      -    araddr[ADDR_W], arvalid in; arready out
//  s_axil_r*       -    rdata[DATA_W], rresp[2], rvalid out; rready in
//  m_axis_tdata    out  NUM_CH*DATA_W   TX data, channel c at [c*DATA_W +: DATA_W]
//  m_axis_tvalid   out  NUM_CH          per-channel TX valid
//  m_axis_tready   in   NUM_CH          per-channel TX ready
//  s_axis_tdata    in   NUM_CH*DATA_W   RX data, same packing as m_axis_tdata
//  s_axis_tvalid   in   NUM_CH          per-channel RX valid
//  s_axis_tready   out  NUM_CH          per-channel RX ready (one-cycle pop pulse)
// BEHAVIOUR
//  Address map:
//   - off = addr - BASE_ADDR; channel stride 0x10; ch = off[7:4].
//   - +0x0 TXDATA (write-only), +0x4 RXDATA (read-only, pops), +0x8 STATUS (read-only).
//   - STATUS bits: [0] tx_full, [1] tx_empty, [2] rx_valid (= s_axis_tvalid[ch]),
//     [15:8] tx_level; all other bits 0.
//   - DECERR (2'b11): off >= NUM_CH*0x10, off[1:0] != 0, or reg index 0xC.
//  Reset: all ready/valid outputs 0, bresp=rresp=2'b00, rdata=0,
//   FIFO pointers/levels cleared (contents discarded); both FSMs -> IDLE.
//   Reset mid-transaction aborts it; no bvalid/rvalid is issued afterwards.
//  Write FSM (states IDLE, ACK, RESP):
//   - IDLE: wait for awvalid&wvalid in the same cycle (T); either alone is ignored.
//     At T, decode and register bresp. TXDATA with FIFO not full: push wdata, OKAY.
//     TXDATA with FIFO full: drop the word, SLVERR (2'b10).
//     Write to RXDATA/STATUS: SLVERR, no side effect. Then -> ACK.
//   - ACK: awready=wready=1 for exactly this one cycle (T+1); bvalid set -> RESP.
//   - RESP: bvalid high from T+2 until bready; on bvalid&bready clear bvalid,
//     bresp -> 00, go IDLE.
//   - Throughput is one write per 3 cycles minimum.
//  Read FSM (states IDLE, ACK, RESP), independent of the write FSM:
//   - IDLE: arvalid at T. RXDATA with s_axis_tvalid[ch]=1: capture tdata,
//     s_axis_tready[ch]=1 at T+1 (single-cycle pop), OKAY.
//     RXDATA with tvalid=0: SLVERR, rdata 0, no pop. STATUS: OKAY, status snapshot at T.
//     Read of TXDATA: SLVERR, rdata 0.
//   - ACK: arready=1 for T+1 only; rvalid set -> RESP.
//   - RESP: rvalid, rdata and rresp held until rready; then rdata=0, rresp=00, go IDLE.
//   - rdata is 0 whenever rvalid=0.
//  TX FIFO, per channel:
//   - First-word-fall-through: m_axis_tvalid = !empty, tdata = head entry.
//   - Pop on tvalid&tready. Pointers wrap modulo TX_DEPTH.
//   - level is ($clog2(TX_DEPTH)+1) bits, zero-extended into STATUS.
//   - A pushed word is visible on m_axis at T+1.
//   - Full is judged at T before any same-cycle pop: write to a full FIFO gets SLVERR
//     even if a pop happens in cycle T. A same-cycle push and pop otherwise both occur;
//     level is unchanged.
//   - m_axis tdata/tvalid never change while tvalid=1 and tready=0.
//  Simultaneous read and write are both serviced; channels are fully independent.
// TESTING
//  1 Reset: aresetn=0 for 3 cycles with random inputs -> all ready/valid outputs 0,
//    STATUS(ch0) reads 0x0000_0002.
//  2 TX burst: write 0xA1..0xA5 to 0x00, m_axis_tready[0]=0 -> first 4 OKAY, 5th SLVERR;
//    then tready=1 -> A1,A2,A3,A4 emitted in order, 0xA5 never appears.
//  3 RX pop: s_axis_tvalid[1]=1, tdata=0xDEAD_BEEF, read 0x14 -> rdata 0xDEADBEEF, OKAY,
//    exactly one tready[1] pulse. Same read with tvalid=0 -> SLVERR, rdata 0, no pulse.
//  4 Decode: read 0x20 with NUM_CH=2 -> DECERR; write 0x02 -> DECERR, FIFO unchanged;
//    write 0x08 -> SLVERR.
//  5 Backpressure and overlap: hold bready=rready=0 for 10 cycles while a write and a read
//    are issued together -> bvalid/rvalid and resp stable, no new aw/ar accepted;
//    FIFO pop during a full-FIFO write still yields SLVERR.
//  6 Reset in RESP (bvalid=1, FIFO level 3) -> next cycle bvalid=0, level 0, m_axis_tvalid=0.

Source files
------------

// File: rtl/axil_stream_bridge_mc.sv
// Multi-channel AXI-Lite slave <-> AXI-Stream bridge.
// Each channel has a TX FIFO (lite write -> m_axis), an RX pop register
// (s_axis -> lite read) and a STATUS register. Full/empty never stall the
// bus; they are reported as SLVERR instead.
module axil_stream_bridge_mc #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       NUM_CH    = 2,
    parameter int unsigned       TX_DEPTH  = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    // AXI-Lite write address / data / response
    input  logic [ADDR_W-1:0]        s_axil_awaddr,
    input  logic                     s_axil_awvalid,
    output logic                     s_axil_awready,
    input  logic [DATA_W-1:0]        s_axil_wdata,
    input  logic                     s_axil_wvalid,
    output logic                     s_axil_wready,
    output logic [1:0]               s_axil_bresp,
    output logic                     s_axil_bvalid,
    input  logic                     s_axil_bready,
    // AXI-Lite read address / data
    input  logic [ADDR_W-1:0]        s_axil_araddr,
    input  logic                     s_axil_arvalid,
    output logic                     s_axil_arready,
    output logic [DATA_W-1:0]        s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    output logic                     s_axil_rvalid,
    input  logic                     s_axil_rready,
    // AXI-Stream TX (per channel)
    output logic [NUM_CH*DATA_W-1:0] m_axis_tdata,
    output logic [NUM_CH-1:0]        m_axis_tvalid,
    input  logic [NUM_CH-1:0]        m_axis_tready,
    // AXI-Stream RX (per channel)
    input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]        s_axis_tvalid,
    output logic [NUM_CH-1:0]        s_axis_tready
);

    localparam int unsigned PTR_W = $clog2(TX_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAck  = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    // Returns {decode_error, reg_index[1:0], channel[3:0]}.
    function automatic logic [6:0] decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        logic              err;
        off = addr - BASE_ADDR;
        err = (off >= ADDR_W'(NUM_CH * 16)) || (off[1:0] != 2'b00) || (off[3:2] == 2'b11);
        return {err, off[3:2], off[7:4]};
    endfunction

    // Per-channel FIFO state exported to the decode logic
    logic [NUM_CH-1:0] tx_full;
    logic [NUM_CH-1:0] tx_empty;
    logic [NUM_CH-1:0] tx_push;
    logic [DATA_W-1:0] status_ch [NUM_CH];

    // Write side
    logic [1:0]  wr_state_q, wr_state_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        bvalid_q, bvalid_d;
    logic [6:0]  wr_dec;
    logic        wr_err;
    logic [1:0]  wr_reg;
    logic [3:0]  wr_ch;
    logic        wr_start;
    logic        wr_sel_full;
    logic [NUM_CH-1:0] wr_hit;

    // Read side
    logic [1:0]        rd_state_q, rd_state_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [NUM_CH-1:0] pop_q, pop_d;
    logic [6:0]        rd_dec;
    logic              rd_err;
    logic [1:0]        rd_reg;
    logic [3:0]        rd_ch;
    logic              rd_start;
    logic [NUM_CH-1:0] rd_hit;
    logic              rd_sel_tvalid;
    logic [DATA_W-1:0] rd_sel_tdata;
    logic [DATA_W-1:0] rd_sel_status;

    assign wr_dec   = decode(s_axil_awaddr);
    assign wr_err   = wr_dec[6];
    assign wr_reg   = wr_dec[5:4];
    assign wr_ch    = wr_dec[3:0];
    assign wr_start = (wr_state_q == StIdle) && s_axil_awvalid && s_axil_wvalid;

    assign rd_dec   = decode(s_axil_araddr);
    assign rd_err   = rd_dec[6];
    assign rd_reg   = rd_dec[5:4];
    assign rd_ch    = rd_dec[3:0];
    assign rd_start = (rd_state_q == StIdle) && s_axil_arvalid;

    // Channel selection for the addressed write and read channels
    always_comb begin
        wr_hit        = '0;
        rd_hit        = '0;
        wr_sel_full   = 1'b0;
        rd_sel_tvalid = 1'b0;
        rd_sel_tdata  = '0;
        rd_sel_status = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_hit[c] = (wr_ch == 4'(c));
            rd_hit[c] = (rd_ch == 4'(c));
            if (wr_hit[c]) begin
                wr_sel_full = tx_full[c];
            end
            if (rd_hit[c]) begin
                rd_sel_tvalid = s_axis_tvalid[c];
                rd_sel_tdata  = s_axis_tdata[c*DATA_W +: DATA_W];
                rd_sel_status = status_ch[c];
            end
        end
    end

    // Full is judged before any same-cycle pop, so a draining FIFO still refuses
    assign tx_push = {NUM_CH{wr_start && !wr_err && (wr_reg == 2'd0)}} & wr_hit & ~tx_full;

    // Write FSM next state
    always_comb begin
        wr_state_d = wr_state_q;
        bresp_d    = bresp_q;
        bvalid_d   = bvalid_q;
        case (wr_state_q)
            StIdle: begin
                if (wr_start) begin
                    wr_state_d = StAck;
                    if (wr_err) begin
                        bresp_d = RespDecerr;
                    end else if (wr_reg == 2'd0) begin
                        bresp_d = wr_sel_full ? RespSlverr : RespOkay;
                    end else begin
                        bresp_d = RespSlverr;
                    end
                end
            end
            StAck: begin
                bvalid_d   = 1'b1;
                wr_state_d = StResp;
            end
            StResp: begin
                if (s_axil_bready) begin
                    bvalid_d   = 1'b0;
                    bresp_d    = RespOkay;
                    wr_state_d = StIdle;
                end
            end
            default: wr_state_d = StIdle;
        endcase
    end

    // Write FSM state
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state_q <= StIdle;
            bresp_q    <= RespOkay;
            bvalid_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            bresp_q    <= bresp_d;
            bvalid_q   <= bvalid_d;
        end
    end

    assign s_axil_awready = (wr_state_q == StAck);
    assign s_axil_wready  = (wr_state_q == StAck);
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;

    // Read FSM next state; pop is a one-cycle pulse issued the cycle after capture
    always_comb begin
        rd_state_d = rd_state_q;
        rresp_d    = rresp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        pop_d      = '0;
        case (rd_state_q)
            StIdle: begin
                if (rd_start) begin
                    rd_state_d = StAck;
                    rdata_d    = '0;
                    if (rd_err) begin
                        rresp_d = RespDecerr;
                    end else if (rd_reg == 2'd1) begin
                        if (rd_sel_tvalid) begin
                            rdata_d = rd_sel_tdata;
                            rresp_d = RespOkay;
                            pop_d   = rd_hit;
                        end else begin
                            rresp_d = RespSlverr;
                        end
                    end else if (rd_reg == 2'd2) begin
                        rdata_d = rd_sel_status;
                        rresp_d = RespOkay;
                    end else begin
                        rresp_d = RespSlverr;
                    end
                end
            end
            StAck: begin
                rvalid_d   = 1'b1;
                rd_state_d = StResp;
            end
            StResp: begin
                if (s_axil_rready) begin
                    rvalid_d   = 1'b0;
                    rresp_d    = RespOkay;
                    rdata_d    = '0;
                    rd_state_d = StIdle;
                end
            end
            default: rd_state_d = StIdle;
        endcase
    end

    // Read FSM state
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_state_q <= StIdle;
            rresp_q    <= RespOkay;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            pop_q      <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rresp_q    <= rresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            pop_q      <= pop_d;
        end
    end

    assign s_axil_arready = (rd_state_q == StAck);
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    // Captured data is held internally until the response phase
    assign s_axil_rdata   = rvalid_q ? rdata_q : '0;
    assign s_axis_tready  = pop_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] mem_q [TX_DEPTH];
        logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
        logic [LVL_W-1:0]  level_q;
        logic              pop;

        assign tx_full[c]  = (level_q == LVL_W'(TX_DEPTH));
        assign tx_empty[c] = (level_q == '0);
        assign pop         = !tx_empty[c] && m_axis_tready[c];

        // First-word-fall-through: head entry is always presented
        assign m_axis_tvalid[c]                 = !tx_empty[c];
        assign m_axis_tdata[c*DATA_W +: DATA_W] = mem_q[rd_ptr_q];

        assign status_ch[c] = DATA_W'({8'(level_q), 5'b0, s_axis_tvalid[c], tx_empty[c],
                                       tx_full[c]});

        // Pointer and level bookkeeping; pointers wrap naturally (power-of-2 depth)
        always_ff @(posedge aclk) begin
            if (!aresetn) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (tx_push[c]) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                if (tx_push[c] && !pop) begin
                    level_q <= level_q + 1'b1;
                end else if (pop && !tx_push[c]) begin
                    level_q <= level_q - 1'b1;
                end
            end
        end

        // Storage is not reset; pointers define validity
        always_ff @(posedge aclk) begin
            if (tx_push[c]) begin
                mem_q[wr_ptr_q] <= s_axil_wdata;
            end
        end
    end

endmodule
